nexthop_scan_ctrl: RTL and testbench

- Sequencer for the findMyBest half of the Q-table/neighbor-table datapath; owns the single-port neighbor table read/write port.
- On a start pulse it walks the table entry-by-entry and selects the best next hop: one-hop CH > fewer hops > max Q-value.
- Q-table update writes from the update path are arbitrated onto the same port with priority over scan reads.
- Sits between the packet filter/update logic and the neighbor table memory; its result feeds the packet builder.

---
 rtl/qtu_pkg.sv | 24 ++
 rtl/hop_compare.sv | 36 +++
 rtl/nexthop_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_nexthop_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qtu_pkg.sv
// Shared types and constants for the Q-table / neighbor-table datapath.
// Used by the next-hop scan sequencer and by the update path.
package qtu_pkg;

  localparam int          WORD_WIDTH_DEF    = 16;
  localparam int          MAX_NEIGHBORS_DEF = 32;
  localparam int          ADDR_WIDTH_DEF    = 5;
  localparam logic [15:0] NO_HOP            = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_DONE
  } state_e;

  // Encoded so that a larger value is a better tier.
  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_HOP2 = 2'd1,
    T_HOP1 = 2'd2
  } tier_e;

endpackage

// File: rtl/hop_compare.sv
// Classifies one neighbor entry into a hop tier and decides whether it beats
// the current best candidate (better tier, or same tier with strictly larger Q).
module hop_compare
  import qtu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] hops,
  input  logic [WIDTH-1:0] my_hops,
  input  logic [WIDTH-1:0] q_value,
  input  logic [WIDTH-1:0] best_q,
  input  logic [1:0]       best_tier,
  output logic [1:0]       tier,
  output logic             better
);

  logic [WIDTH-1:0] my_hops_m1;

  assign my_hops_m1 = my_hops - WIDTH'(1);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    tier = T_NONE;
    if (hops == my_hops_m1) begin
      tier = T_HOP1;
    end else if (hops == my_hops) begin
      tier = T_HOP2;
    end
  end

  // Equal Q within the same tier is not "better", so earlier entries win ties.
  assign better = (tier != T_NONE) &&
                  ((tier > best_tier) || ((tier == best_tier) && (q_value > best_q)));

endmodule

// File: rtl/nexthop_scan_ctrl.sv
// findMyBest sequencer: walks the neighbor table once per start pulse and
// selects the best next hop, sharing the table port with update writes.
module nexthop_scan_ctrl
  import qtu_pkg::*;
#(
  parameter int WORD_WIDTH    = WORD_WIDTH_DEF,
  parameter int MAX_NEIGHBORS = MAX_NEIGHBORS_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] myHopsFromCH,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] neighborCount,
  input  logic                  upd_req,
  output logic                  upd_gnt,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  input  logic [WORD_WIDTH-1:0] mNodeHops,
  input  logic [WORD_WIDTH-1:0] mNodeQValue,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] nextHop,
  output logic [WORD_WIDTH-1:0] nextHopQ,
  output logic                  found,
  output logic                  done
);

  localparam logic [WORD_WIDTH-1:0] MAX_CNT  = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] NO_HOP_W = WORD_WIDTH'(NO_HOP);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [WORD_WIDTH-1:0]   my_hops_q, my_hops_d;
  logic [WORD_WIDTH-1:0]   cnt_q, cnt_d;
  tier_e                   best_tier_q, best_tier_d;
  logic [WORD_WIDTH-1:0]   best_id_q, best_id_d;
  logic [WORD_WIDTH-1:0]   best_qv_q, best_qv_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    found_q, found_d;
  logic [WORD_WIDTH-1:0]   next_hop_q, next_hop_d;
  logic [WORD_WIDTH-1:0]   next_hop_qv_q, next_hop_qv_d;

  logic [WORD_WIDTH-1:0]   cnt_clamped;
  logic                    last_entry;
  logic [1:0]              cmp_tier;
  logic                    cmp_better;

  hop_compare #(
    .WIDTH (WORD_WIDTH)
  ) u_hop_compare (
    .hops      (mNodeHops),
    .my_hops   (my_hops_q),
    .q_value   (mNodeQValue),
    .best_q    (best_qv_q),
    .best_tier (best_tier_q),
    .tier      (cmp_tier),
    .better    (cmp_better)
  );

  assign cnt_clamped = (neighborCount > MAX_CNT) ? MAX_CNT : neighborCount;
  assign last_entry  = ({{(WORD_WIDTH-ADDR_WIDTH){1'b0}}, idx_q} == (cnt_q - WORD_WIDTH'(1)));

  // Writes from the update path always win the port; a scan read simply waits.
  assign upd_gnt  = upd_req;
  assign mem_addr = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign found    = found_q;
  assign nextHop  = next_hop_q;
  assign nextHopQ = next_hop_qv_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    my_hops_d     = my_hops_q;
    cnt_d         = cnt_q;
    best_tier_d   = best_tier_q;
    best_id_d     = best_id_q;
    best_qv_d     = best_qv_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    found_d       = found_q;
    next_hop_d    = next_hop_q;
    next_hop_qv_d = next_hop_qv_q;
    mem_rd_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          my_hops_d   = myHopsFromCH;
          cnt_d       = cnt_clamped;
          idx_d       = '0;
          best_tier_d = T_NONE;
          best_id_d   = NO_HOP_W;
          best_qv_d   = '0;
          busy_d      = 1'b1;
          if (myHopsFromCH == '0) begin
            state_d = S_DONE;
          end else if (myHopsFromCH == WORD_WIDTH'(1)) begin
            // One hop from the CH: send straight to it, no table walk needed.
            best_tier_d = T_HOP1;
            best_id_d   = chosenCH;
            state_d     = S_DONE;
          end else if (cnt_clamped == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        if (!upd_req) begin
          mem_rd_en = 1'b1;
          state_d   = S_EVAL;
        end
      end

      S_EVAL: begin
        if (cmp_better) begin
          best_tier_d = tier_e'(cmp_tier);
          best_id_d   = mNodeID;
          best_qv_d   = mNodeQValue;
        end
        if (last_entry) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_WIDTH'(1);
          state_d = S_READ;
        end
      end

      S_DONE: begin
        found_d       = (best_tier_q != T_NONE);
        next_hop_d    = (best_tier_q != T_NONE) ? best_id_q : NO_HOP_W;
        next_hop_qv_d = (best_tier_q != T_NONE) ? best_qv_q : '0;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before the edge regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      my_hops_q     <= '0;
      cnt_q         <= '0;
      best_tier_q   <= T_NONE;
      best_id_q     <= NO_HOP_W;
      best_qv_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      next_hop_q    <= NO_HOP_W;
      next_hop_qv_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      my_hops_q     <= my_hops_d;
      cnt_q         <= cnt_d;
      best_tier_q   <= best_tier_d;
      best_id_q     <= best_id_d;
      best_qv_q     <= best_qv_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      found_q       <= found_d;
      next_hop_q    <= next_hop_d;
      next_hop_qv_q <= next_hop_qv_d;
    end
  end

endmodule

// File: tb/tb_nexthop_scan_ctrl.sv
// Directed, table-driven bench for nexthop_scan_ctrl with a behavioural
// 1-cycle-latency neighbor table and hand-written stall/reset sequences.
module tb_nexthop_scan_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] myHopsFromCH;
  logic [15:0] chosenCH;
  logic [15:0] neighborCount;
  logic        upd_req;
  logic        upd_gnt;
  logic        mem_rd_en;
  logic [4:0]  mem_addr;
  logic [15:0] mNodeID;
  logic [15:0] mNodeHops;
  logic [15:0] mNodeQValue;
  logic        busy;
  logic [15:0] nextHop;
  logic [15:0] nextHopQ;
  logic        found;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] mem_id   [32];
  logic [15:0] mem_hops [32];
  logic [15:0] mem_q    [32];

  typedef struct {
    logic [15:0]       my_hops;
    logic [15:0]       ch;
    logic [15:0]       cnt;
    logic [2:0][15:0]  id;
    logic [2:0][15:0]  hops;
    logic [2:0][15:0]  q;
    logic [15:0]       exp_hop;
    logic [15:0]       exp_q;
    logic              exp_found;
    int                exp_cycles;
    int                exp_reads;
  } vec_t;

  vec_t vecs [9];
  vec_t clamp_v;

  nexthop_scan_ctrl dut (
    .clk           (clk),
    .nrst          (nrst),
    .start         (start),
    .myHopsFromCH  (myHopsFromCH),
    .chosenCH      (chosenCH),
    .neighborCount (neighborCount),
    .upd_req       (upd_req),
    .upd_gnt       (upd_gnt),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mNodeID       (mNodeID),
    .mNodeHops     (mNodeHops),
    .mNodeQValue   (mNodeQValue),
    .busy          (busy),
    .nextHop       (nextHop),
    .nextHopQ      (nextHopQ),
    .found         (found),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mNodeID     <= mem_id[mem_addr];
      mNodeHops   <= mem_hops[mem_addr];
      mNodeQValue <= mem_q[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic [15:0] mh, ch, cnt,
    input logic [15:0] i0, h0, q0, i1, h1, q1, i2, h2, q2,
    input logic [15:0] eh, eq, input logic ef, input int ec, input int er);
    vec_t v;
    v.my_hops = mh; v.ch = ch; v.cnt = cnt;
    v.id[0] = i0; v.hops[0] = h0; v.q[0] = q0;
    v.id[1] = i1; v.hops[1] = h1; v.q[1] = q1;
    v.id[2] = i2; v.hops[2] = h2; v.q[2] = q2;
    v.exp_hop = eh; v.exp_q = eq; v.exp_found = ef;
    v.exp_cycles = ec; v.exp_reads = er;
    return v;
  endfunction

  // Unused slots get a hop count no test ever matches.
  task automatic load_table(input vec_t v);
    for (int i = 0; i < 32; i++) begin
      mem_id[i]   = 16'(100 + i);
      mem_hops[i] = 16'hF000;
      mem_q[i]    = 16'd0;
    end
    for (int i = 0; i < 3; i++) begin
      mem_id[i]   = v.id[i];
      mem_hops[i] = v.hops[i];
      mem_q[i]    = v.q[i];
    end
  endtask

  // Cycles are counted in clock edges after the cycle that carries start.
  task automatic run_scan(input int stall_at, input int stall_len, input int extra_start_at,
                          output int cycles, output int reads, output int gnts,
                          output int conflicts);
    @(negedge clk);
    start = 1'b1;
    cycles = 0; reads = 0; gnts = 0; conflicts = 0;
    forever begin
      @(negedge clk);
      cycles++;
      start = (cycles == extra_start_at);
      if (cycles == extra_start_at) begin
        myHopsFromCH  = 16'd1;
        chosenCH      = 16'd55;
        neighborCount = 16'd0;
      end
      upd_req = (stall_len > 0) && (cycles >= stall_at) && (cycles < stall_at + stall_len);
      #1;
      if (mem_rd_en === 1'b1) reads++;
      if (upd_gnt === 1'b1) gnts++;
      if ((upd_gnt === 1'b1 && mem_rd_en === 1'b1) || (upd_gnt !== upd_req)) conflicts++;
      if (done === 1'b1) break;
      if (cycles >= 200) break;
    end
    upd_req = 1'b0;
    start   = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int stall_at, input int stall_len,
                           input int extra_start_at, input string tag);
    int cycles, reads, gnts, conflicts;
    myHopsFromCH  = v.my_hops;
    chosenCH      = v.ch;
    neighborCount = v.cnt;
    run_scan(stall_at, stall_len, extra_start_at, cycles, reads, gnts, conflicts);
    check({tag, "_done_cycle"}, 32'(cycles), 32'(v.exp_cycles + stall_len));
    check({tag, "_nextHop"},    32'(nextHop), 32'(v.exp_hop));
    check({tag, "_nextHopQ"},   32'(nextHopQ), 32'(v.exp_q));
    check({tag, "_found"},      32'(found), 32'(v.exp_found));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_reads"},      32'(reads), 32'(v.exp_reads));
    check({tag, "_gnt_cycles"}, 32'(gnts), 32'(stall_len));
    check({tag, "_port_conflicts"}, 32'(conflicts), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_result_held"},    32'(nextHop), 32'(v.exp_hop));
  endtask

  initial begin
    int   seen_done;
    nrst          = 1'b0;
    start         = 1'b0;
    upd_req       = 1'b0;
    myHopsFromCH  = '0;
    chosenCH      = '0;
    neighborCount = '0;

    //                 myH  CH   cnt  e0: id hop q      e1: id hop q      e2: id hop q        nextHop    Q  fnd cyc rd
    vecs[0] = mk(16'd1, 16'd7, 16'd3, 16'd5, 16'd2, 16'd40, 16'd6, 16'd2, 16'd90, 16'd8, 16'd3, 16'd200, 16'd7,     16'd0,   1'b1, 2, 0);
    vecs[1] = mk(16'd3, 16'd0, 16'd3, 16'd5, 16'd2, 16'd40, 16'd6, 16'd2, 16'd90, 16'd8, 16'd3, 16'd200, 16'd6,     16'd90,  1'b1, 8, 3);
    vecs[2] = mk(16'd3, 16'd0, 16'd3, 16'd9, 16'd3, 16'd10, 16'd4, 16'd3, 16'd10, 16'd2, 16'd5, 16'd99,  16'd9,     16'd10,  1'b1, 8, 3);
    vecs[3] = mk(16'd3, 16'd0, 16'd0, 16'd5, 16'd2, 16'd40, 16'd6, 16'd2, 16'd90, 16'd8, 16'd3, 16'd200, 16'hFFFF,  16'd0,   1'b0, 2, 0);
    vecs[4] = mk(16'd0, 16'd7, 16'd3, 16'd5, 16'd2, 16'd40, 16'd6, 16'd2, 16'd90, 16'd8, 16'd3, 16'd200, 16'hFFFF,  16'd0,   1'b0, 2, 0);
    vecs[5] = mk(16'd2, 16'd0, 16'd3, 16'd11, 16'd2, 16'd50, 16'd12, 16'd1, 16'd5, 16'd13, 16'd1, 16'd5, 16'd12,    16'd5,   1'b1, 8, 3);
    vecs[6] = mk(16'd4, 16'd0, 16'd3, 16'd1, 16'd7, 16'd1,  16'd2, 16'd0, 16'd9,  16'd3, 16'd9, 16'd9,   16'hFFFF,  16'd0,   1'b0, 8, 3);
    vecs[7] = mk(16'd2, 16'd0, 16'd2, 16'd20, 16'd1, 16'd3, 16'd21, 16'd1, 16'd4, 16'd22, 16'd1, 16'd100, 16'd21,   16'd4,   1'b1, 6, 2);
    vecs[8] = mk(16'd3, 16'd0, 16'd3, 16'd30, 16'd2, 16'd0, 16'd31, 16'd3, 16'd500, 16'd32, 16'd2, 16'd0, 16'd30,   16'd0,   1'b1, 8, 3);
    clamp_v = mk(16'd3, 16'd0, 16'd40, 16'd60, 16'd3, 16'd900, 16'd61, 16'hF000, 16'd0, 16'd62, 16'hF000, 16'd0,
                 16'd77, 16'd5, 1'b1, 66, 32);

    #12;
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_done",      32'(done), 32'd0);
    check("rst_found",     32'(found), 32'd0);
    check("rst_nextHop",   32'(nextHop), 32'hFFFF);
    check("rst_nextHopQ",  32'(nextHopQ), 32'd0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_mem_addr",  32'(mem_addr), 32'd0);
    check("rst_upd_gnt",   32'(upd_gnt), 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      load_table(vecs[i]);
      apply_vec(vecs[i], 0, 0, 0, $sformatf("vec%0d", i));
    end

    // Write stalls while entry 1 is waiting for the port.
    load_table(vecs[1]);
    apply_vec(vecs[1], 3, 3, 0, "stall3");

    // A second start mid-scan, with all inputs changed, must be ignored.
    load_table(vecs[1]);
    apply_vec(vecs[1], 0, 0, 3, "restart_busy");

    // Count above table depth is clamped; best entry sits at the last index.
    load_table(clamp_v);
    mem_id[31] = 16'd77; mem_hops[31] = 16'd2; mem_q[31] = 16'd5;
    apply_vec(clamp_v, 0, 0, 0, "clamp");

    // Asynchronous reset in the middle of a scan that previously found a hop.
    load_table(vecs[1]);
    myHopsFromCH  = vecs[1].my_hops;
    chosenCH      = vecs[1].ch;
    neighborCount = vecs[1].cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("midrst_busy",      32'(busy), 32'd0);
    check("midrst_found",     32'(found), 32'd0);
    check("midrst_nextHop",   32'(nextHop), 32'hFFFF);
    check("midrst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("midrst_mem_addr",  32'(mem_addr), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    apply_vec(vecs[1], 0, 0, 0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
